// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: steps an external 1-bit full-adder cell
// LSB-first over WIDTH cycles and reports result plus Y86-64 ZF/SF/OF.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;

    // Full-adder cell is only driven while a bit is being processed.
    assign fa_a   = (state_q == S_RUN) ? a_sh_q[0] : 1'b0;
    assign fa_b   = (state_q == S_RUN) ? b_sh_q[0] : 1'b0;
    assign fa_cin = (state_q == S_RUN) ? carry_q   : 1'b0;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = sub ? ~b : b;
                    carry_d  = sub;
                    idx_d    = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                idx_d    = idx_q + CNT_W'(1);
                if (idx_q == LAST_IDX) begin
                    // carry_q is the carry into the MSB, fa_cout the carry out of it
                    zf_d    = (result_d == '0);
                    sf_d    = fa_sum;
                    of_d    = carry_q ^ fa_cout;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: full-adder cell model, arithmetic reference
// model checked every cycle, plus directed operations with literal results.
module tb_serial_addsub_ctrl;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, sub;
    logic [WIDTH-1:0] a, b;
    logic             fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic             busy, done, zf, sf, of;
    logic [WIDTH-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    serial_addsub_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
        .busy(busy), .done(done), .result(result), .zf(zf), .sf(sf), .of(of)
    );

    always #5 clk = ~clk;

    // External 1-bit full-adder cell
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    task automatic chk(input string nm, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference arithmetic in a wider signed domain
    function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        return s ? (x - y) : (x + y);
    endfunction

    function automatic logic ref_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        logic signed [WIDTH:0] ex, ey, r;
        ex = $signed({x[WIDTH-1], x});
        ey = $signed({y[WIDTH-1], y});
        r  = s ? (ex - ey) : (ex + ey);
        return r[WIDTH] ^ r[WIDTH-1];
    endfunction

    // Model: accept in idle, busy for WIDTH+1 cycles, done on the last one
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_a = '0, m_bx = '0, m_res = '0;
    logic             m_sub = 1'b0, m_zf = 1'b0, m_sf = 1'b0, m_of = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_a <= '0; m_bx <= '0; m_sub <= 1'b0;
            m_res <= '0; m_zf <= 1'b0; m_sf <= 1'b0; m_of <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt <= WIDTH + 1;
                m_a   <= a;
                m_bx  <= sub ? ~b : b;
                m_sub <= sub;
                m_res <= ref_res(a, b, sub);
                m_zf  <= (ref_res(a, b, sub) == '0);
                m_sf  <= ref_res(a, b, sub) >> (WIDTH - 1) != '0;
                m_of  <= ref_of(a, b, sub);
            end
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    // Per-cycle compare against the model
    int               c_idx;
    logic [WIDTH-1:0] c_sum, c_cvec;
    always @(negedge clk) begin
        chk("busy", WIDTH'(busy), WIDTH'(m_cnt != 0));
        chk("done", WIDTH'(done), WIDTH'(m_cnt == 1));
        if (m_cnt >= 2) begin
            c_idx  = WIDTH + 1 - m_cnt;
            c_sum  = m_a + m_bx + WIDTH'(m_sub);
            c_cvec = c_sum ^ m_a ^ m_bx;
            chk("fa_a_run", WIDTH'(fa_a), WIDTH'(m_a[c_idx]));
            chk("fa_b_run", WIDTH'(fa_b), WIDTH'(m_bx[c_idx]));
            chk("fa_cin_run", WIDTH'(fa_cin), WIDTH'(c_cvec[c_idx]));
        end else begin
            chk("fa_idle", WIDTH'({fa_a, fa_b, fa_cin}), '0);
            chk("result", result, m_res);
            chk("flags", WIDTH'({zf, sf, of}), WIDTH'({m_zf, m_sf, m_of}));
        end
    end

    // One operation with literal expectations; returns in the idle cycle after done
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xs,
                          input logic [WIDTH-1:0] er, input logic ez, input logic es, input logic eo);
        int   cyc;
        logic got;
        @(negedge clk);
        a = xa; b = xb; sub = xs; start = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
            if (done) got = 1'b1;
        end
        chk("latency", WIDTH'(cyc), WIDTH'(65));
        chk("lit_result", result, er);
        chk("lit_zf", WIDTH'(zf), WIDTH'(ez));
        chk("lit_sf", WIDTH'(sf), WIDTH'(es));
        chk("lit_of", WIDTH'(of), WIDTH'(eo));
        @(negedge clk);
        chk("idle_after_done", WIDTH'(busy), '0);
    endtask

    int   n_done;
    logic [WIDTH-1:0] last_res;

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_outs", WIDTH'({busy, done, zf, sf, of, fa_a, fa_b, fa_cin}), '0);
        rst_n = 1'b1;

        run_op(64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);
        run_op(64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        run_op(64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        run_op(64'd3, 64'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1'b0);

        // start held high while busy: only the first request runs
        @(negedge clk);
        a = 64'd1; b = 64'd1; sub = 1'b0; start = 1'b1;
        n_done = 0; last_res = '0;
        repeat (20) begin
            @(negedge clk);
            a = 64'd77; b = 64'd3;
            if (done) begin n_done++; last_res = result; end
        end
        start = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (done) begin n_done++; last_res = result; end
        end
        chk("held_start_dones", WIDTH'(n_done), WIDTH'(1));
        chk("held_start_result", last_res, 64'd2);

        // reset mid-run aborts the operation
        @(negedge clk);
        a = 64'd9; b = 64'd4; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outs", WIDTH'({busy, done, zf, sf, of, fa_a, fa_b, fa_cin}), '0);
        chk("abort_result", result, '0);
        rst_n = 1'b1;
        n_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", WIDTH'(n_done), '0);
        run_op(64'd9, 64'd4, 1'b0, 64'd13, 1'b0, 1'b0, 1'b0);

        // back-to-back: start in the idle cycle right after done
        run_op(64'd100, 64'd1, 1'b1, 64'd99, 1'b0, 1'b0, 1'b0);
        run_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
